sp_ram_arbiter: RTL and testbench

//  Shares one single-port read-first RAM (SpRamRf: addr/we/din in, registered qout)

---
 rtl/sp_ram_pkg.sv | 21 ++
 rtl/SpRamRf.sv | 23 ++
 rtl/rr_arbiter.sv | 57 +++++
 rtl/sp_ram_arbiter.sv | 118 +++++++++++
 tb/tb_sp_ram_arbiter.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/sp_ram_pkg.sv
// Shared types and constants for the single-port RAM arbiter.
package sp_ram_pkg;

    localparam int NREQ_DEF = 4;
    localparam int AW_DEF   = 8;
    localparam int DW_DEF   = 8;
    localparam int IDW      = $clog2(NREQ_DEF);

    // One RAM access as presented to the memory macro.
    typedef struct packed {
        logic              we;
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] data;
    } ram_req_t;

    // Round-robin successor: the requester after g, wrapping at n.
    function automatic int rr_next(input int g, input int n);
        return (g + 1) % n;
    endfunction

endpackage

// File: rtl/SpRamRf.sv
// Single-port read-first RAM with registered output.
module SpRamRf #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] qout
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Read returns the contents before this cycle's write lands.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        qout <= mem[addr];
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant scanning from a rotating pointer.
module rr_arbiter
    import sp_ram_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 advance,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id
);

    localparam int PW = $clog2(N);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic          found;

    // First requester at or after the pointer wins; nothing is granted in reset.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        for (int k = 0; k < N; k++) begin
            automatic int idx = (int'(ptr_q) + k) % N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = PW'(idx);
            end
        end
        if (rst) begin
            gnt    = '0;
            gnt_id = '0;
        end
    end

    // Pointer moves just past the winner on an accepted access, otherwise holds.
    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = PW'(rr_next(int'(gnt_id), N));
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Shares one single-port read-first RAM between NREQ requesters with a
// fixed two-cycle accept-to-response pipeline and no back-pressure.
module sp_ram_arbiter
    import sp_ram_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ-1:0]   req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [DW-1:0]     rsp_rdata,
    output logic [AW-1:0]     ram_addr,
    output logic              ram_we,
    output logic [DW-1:0]     ram_din,
    input  logic [DW-1:0]     ram_qout
);

    localparam int IW = $clog2(NREQ);

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_id;
    logic            accept;
    req_t            win;

    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic          ram_we_q,   ram_we_d;
    logic [DW-1:0] ram_din_q,  ram_din_d;
    logic [IW-1:0] s1_id_q,    s1_id_d;
    logic          s1_v_q,     s1_v_d;
    logic [IW-1:0] s2_id_q,    s2_id_d;
    logic          s2_v_q,     s2_v_d;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (accept),
        .gnt     (gnt),
        .gnt_id  (gnt_id)
    );

    assign req_ready = gnt;
    assign accept    = |(req_valid & gnt);

    // Select the winning requester's access fields.
    always_comb begin
        win.we   = req_we[gnt_id];
        win.addr = req_addr[int'(gnt_id)*AW +: AW];
        win.data = req_wdata[int'(gnt_id)*DW +: DW];
    end

    // Stage 1 loads the winner into the RAM control regs; stage 2 tracks the id.
    always_comb begin
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        ram_we_d   = 1'b0;
        s1_id_d    = s1_id_q;
        s1_v_d     = 1'b0;
        if (accept) begin
            ram_addr_d = win.addr;
            ram_din_d  = win.data;
            ram_we_d   = win.we;
            s1_id_d    = gnt_id;
            s1_v_d     = 1'b1;
        end
        s2_id_d = s1_id_q;
        s2_v_d  = s1_v_q;
    end

    // Pipeline registers; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_addr_q <= '0;
            ram_we_q   <= 1'b0;
            ram_din_q  <= '0;
            s1_id_q    <= '0;
            s1_v_q     <= 1'b0;
            s2_id_q    <= '0;
            s2_v_q     <= 1'b0;
        end else begin
            ram_addr_q <= ram_addr_d;
            ram_we_q   <= ram_we_d;
            ram_din_q  <= ram_din_d;
            s1_id_q    <= s1_id_d;
            s1_v_q     <= s1_v_d;
            s2_id_q    <= s2_id_d;
            s2_v_q     <= s2_v_d;
        end
    end

    assign ram_addr = ram_addr_q;
    assign ram_we   = ram_we_q;
    assign ram_din  = ram_din_q;

    // Decode the completion strobe; data bus is the RAM output, zero when idle.
    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        if (s2_v_q && !rst) begin
            rsp_valid[s2_id_q] = 1'b1;
            rsp_rdata          = ram_qout;
        end
    end

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed bench for sp_ram_arbiter + SpRamRf with a response scoreboard.
module tb_sp_ram_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 8;
    localparam int DW   = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]   rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic [AW-1:0]     ram_addr;
    logic              ram_we;
    logic [DW-1:0]     ram_din;
    logic [DW-1:0]     ram_qout;

    always #5 clk = ~clk;

    sp_ram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_din   (ram_din),
        .ram_qout  (ram_qout)
    );

    SpRamRf #(.AW(AW), .DW(DW)) u_ram (
        .clk  (clk),
        .addr (ram_addr),
        .we   (ram_we),
        .din  (ram_din),
        .qout (ram_qout)
    );

    typedef struct {
        int         due;
        int         id;
        logic [7:0] data;
        bit         chk;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mm [256];
    bit         kn [256];
    int         ptr_m    = 0;
    int         cyc      = 0;
    int         n_chk    = 0;
    int         n_fail   = 0;
    logic       exp_we   = 1'b0;
    bit         prev_rst = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic set_req(input int i, input bit we, input logic [7:0] a, input logic [7:0] d);
        req_valid[i]       = 1'b1;
        req_we[i]          = we;
        req_addr[i*8 +: 8] = a;
        req_wdata[i*8 +: 8] = d;
    endtask

    task automatic clr_all();
        req_valid = '0;
        req_we    = '0;
    endtask

    // One clock: check outputs at the falling edge against the model, then advance.
    task automatic tick();
        exp_t            e;
        logic [NREQ-1:0] exp_v;
        logic [NREQ-1:0] exp_g;
        logic [7:0]      exp_d;
        logic [7:0]      a;
        bit              dchk;
        int              g;
        @(negedge clk);
        if (rst) sb.delete();
        exp_v = '0;
        exp_d = '0;
        dchk  = 1'b0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e            = sb.pop_front();
            exp_v[e.id]  = 1'b1;
            exp_d        = e.data;
            dchk         = e.chk;
        end
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
        if (dchk) chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_d));
        chk("ram_we", 32'(ram_we), 32'(exp_we));
        if (prev_rst) begin
            chk("ram_addr_rst", 32'(ram_addr), 32'd0);
            chk("ram_din_rst", 32'(ram_din), 32'd0);
            chk("rsp_rdata_rst", 32'(rsp_rdata), 32'd0);
        end
        g = -1;
        if (!rst) begin
            for (int k = 0; k < NREQ; k++) begin
                automatic int idx = (ptr_m + k) % NREQ;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        exp_g = (g >= 0) ? NREQ'(1 << g) : '0;
        chk("req_ready", 32'(req_ready), 32'(exp_g));
        exp_we = 1'b0;
        if (rst) begin
            ptr_m = 0;
        end else if (g >= 0) begin
            a = req_addr[g*8 +: 8];
            sb.push_back('{cyc + 2, g, mm[a], kn[a]});
            if (req_we[g]) begin
                mm[a]  = req_wdata[g*8 +: 8];
                kn[a]  = 1'b1;
                exp_we = 1'b1;
            end
            ptr_m = (g + 1) % NREQ;
        end
        $display("cyc %0d rst=%0b valid=%b ready=%b rsp_valid=%b rsp_rdata=%02h", cyc, rst, req_valid, req_ready, rsp_valid, rsp_rdata);
        prev_rst = rst;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        // Reset with every requester asserting valid.
        rst       = 1'b1;
        req_valid = '1;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        @(posedge clk);
        #1;
        cyc = 1;
        tick();
        tick();
        rst = 1'b0;
        clr_all();

        // Single requester write then read of the same word.
        set_req(0, 1'b1, 8'h01, 8'h10);
        tick();
        clr_all();
        set_req(0, 1'b0, 8'h01, 8'h00);
        tick();
        clr_all();
        // Requester 3 reads it back too, bringing the pointer back to 0.
        set_req(3, 1'b0, 8'h01, 8'h00);
        tick();
        clr_all();
        tick();
        tick();

        // Fairness: all four valid for eight cycles.
        set_req(0, 1'b1, 8'h02, 8'h20);
        set_req(1, 1'b0, 8'h02, 8'h00);
        set_req(2, 1'b1, 8'h01, 8'h30);
        set_req(3, 1'b0, 8'h01, 8'h00);
        for (int i = 0; i < 8; i++) tick();
        clr_all();
        tick();
        tick();

        // Read-first: clear 0x0a, overwrite it, read it the very next cycle.
        set_req(1, 1'b1, 8'h0a, 8'h00);
        tick();
        set_req(1, 1'b1, 8'h0a, 8'hA0);
        tick();
        clr_all();
        set_req(2, 1'b0, 8'h0a, 8'h00);
        tick();
        clr_all();
        tick();
        tick();

        // Skip and wrap: pointer at 3 with only r1 and r3 valid.
        set_req(1, 1'b0, 8'h0a, 8'h00);
        set_req(3, 1'b0, 8'h01, 8'h00);
        tick();
        tick();
        clr_all();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 8'h0a, 8'h00);
        tick();
        clr_all();
        tick();
        tick();

        // Reset one cycle after accepting a read; nothing may complete.
        set_req(0, 1'b0, 8'h01, 8'h00);
        tick();
        clr_all();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 8'h02, 8'h00);
        tick();
        clr_all();
        tick();
        tick();
        tick();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
